hyperbus_w2phy: RTL

- Write-direction data splitter between the AXI write-data channel and the Hyperbus PHY TX path.
- Accepts one AXI W beat at a time into a register and emits it as a sequence of PHY words of 16*NumPhys bits, each with a per-byte strobe.
- Handles unaligned start addresses, narrow transfers (size below bus width) and PHY back-pressure.
- The register stage cuts the combinational path between the AXI slave and the PHY-side CDC FIFO.

---
 rtl/hyperbus_w2phy.sv | 121 ++++++++++++
 1 files changed

// File: rtl/hyperbus_w2phy.sv
// Write-data splitter: registers one AXI W beat, then emits it as a stream of
// 2*NumPhys-byte PHY words with per-byte strobes masked to the beat's valid window.
module hyperbus_w2phy #(
    parameter int AxiDataWidth = 64,
    parameter int NumPhys      = 2,
    parameter int BurstLength  = 8,
    parameter int AddrWidth    = $clog2(AxiDataWidth/8)
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      trans_handshake,
    input  logic                      is_a_read,
    input  logic [AddrWidth-1:0]      start_addr,
    input  logic [2:0]                size,
    input  logic [BurstLength-1:0]    burst_len,
    input  logic                      axi_valid_i,
    output logic                      axi_ready_o,
    input  logic [AxiDataWidth-1:0]   axi_data_i,
    input  logic [AxiDataWidth/8-1:0] axi_strb_i,
    input  logic                      axi_last_i,
    output logic                      phy_valid_o,
    input  logic                      phy_ready_i,
    output logic [16*NumPhys-1:0]     phy_data_o,
    output logic [2*NumPhys-1:0]      phy_strb_o,
    output logic                      phy_last_o,
    output logic                      last_err_o
);
    localparam int Npb    = 2*NumPhys;
    localparam int NpbLog = $clog2(Npb);
    localparam int PhyW   = 8*Npb;
    localparam int StrbW  = AxiDataWidth/8;

    typedef enum logic [1:0] {Idle, WaitBeat, Send} state_e;

    state_e                  state;
    logic [BurstLength-1:0]  axi_addr, beat_end, phy_cnt, beats_left;
    logic [2:0]              size_q;
    logic [AxiDataWidth-1:0] data_q;
    logic [StrbW-1:0]        strb_q;

    logic [BurstLength-1:0]          next_cnt;
    logic                            word_done;
    logic [AddrWidth-1:0]            word_idx;
    logic [Npb-1:0]                  strb_w;
    logic [Npb-1:0][BurstLength-1:0] byte_pos;

    assign next_cnt  = phy_cnt + BurstLength'(Npb);
    assign word_done = next_cnt >= beat_end;
    // Lane selection uses only the low address bits, so addresses wrap across the bus.
    assign word_idx  = phy_cnt[AddrWidth-1:0] >> NpbLog;
    assign strb_w    = Npb'(strb_q >> (Npb * int'(word_idx)));

    for (genvar j = 0; j < Npb; j++) begin : g_pos
        assign byte_pos[j] = phy_cnt + BurstLength'(j);
    end

    // Data-path outputs are gated by the valid flop so reset forces them to 0 at once.
    always_comb begin
        phy_data_o = '0;
        phy_strb_o = '0;
        phy_last_o = 1'b0;
        if (phy_valid_o) begin
            phy_data_o = PhyW'(data_q >> (PhyW * int'(word_idx)));
            for (int j = 0; j < Npb; j++)
                phy_strb_o[j] = strb_w[j] && (byte_pos[j] >= axi_addr) && (byte_pos[j] < beat_end);
            phy_last_o = (beats_left == '0) && word_done;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= Idle;
            axi_addr    <= '0;
            beat_end    <= '0;
            phy_cnt     <= '0;
            beats_left  <= '0;
            size_q      <= '0;
            data_q      <= '0;
            strb_q      <= '0;
            axi_ready_o <= 1'b0;
            phy_valid_o <= 1'b0;
            last_err_o  <= 1'b0;
        end else begin
            last_err_o <= 1'b0;
            case (state)
                Idle: if (trans_handshake && !is_a_read) begin
                    axi_addr    <= BurstLength'(start_addr);
                    size_q      <= size;
                    beats_left  <= burst_len;
                    axi_ready_o <= 1'b1;
                    state       <= WaitBeat;
                end
                WaitBeat: if (axi_valid_i) begin
                    data_q      <= axi_data_i;
                    strb_q      <= axi_strb_i;
                    beat_end    <= ((axi_addr >> size_q) << size_q) + (BurstLength'(1) << size_q);
                    phy_cnt     <= axi_addr & ~BurstLength'(Npb - 1);
                    last_err_o  <= axi_last_i != (beats_left == '0);
                    axi_ready_o <= 1'b0;
                    phy_valid_o <= 1'b1;
                    state       <= Send;
                end
                Send: if (phy_ready_i) begin
                    phy_cnt <= next_cnt;
                    if (word_done) begin
                        axi_addr    <= beat_end;
                        beats_left  <= beats_left - 1'b1;
                        phy_valid_o <= 1'b0;
                        if (beats_left == '0) begin
                            state <= Idle;
                        end else begin
                            state       <= WaitBeat;
                            axi_ready_o <= 1'b1;
                        end
                    end
                end
                default: state <= Idle;
            endcase
        end
    end
endmodule
